// File: rtl/bpu_pkg.sv
// Shared encodings for the branch prediction unit controller.
package bpu_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'b00,
        RUN     = 2'b01,
        RECOVER = 2'b10
    } bpu_state_e;

    typedef enum logic [1:0] {
        BTB_NOP   = 2'b00,
        BTB_WRITE = 2'b01,
        BTB_INVAL = 2'b10
    } btb_op_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/bpu_mispredict_detect.sv
// Combinational resolution decode: mispredict flag, corrected fetch PC and table ops.
module bpu_mispredict_detect
    import bpu_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic            res_valid_i,
    input  logic            res_branch_i,
    input  logic            res_btb_hit_i,
    input  logic            res_predict_taken_i,
    input  logic            res_taken_i,
    input  logic [PC_W-1:0] res_pc_i,
    input  logic [PC_W-1:0] res_target_i,
    output logic            mis_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            upd_bht_o,
    output logic [1:0]      upd_btb_o
);

    // A non-branch that hit the BTB and was predicted taken fetched down a bogus path.
    assign mis_o = res_valid_i &&
                   ((res_branch_i && (res_predict_taken_i != res_taken_i)) ||
                    (!res_branch_i && res_btb_hit_i && res_predict_taken_i));

    assign redirect_pc_o = (res_branch_i && res_taken_i) ? res_target_i
                                                         : res_pc_i + PC_W'(PC_INC);

    assign upd_bht_o = res_branch_i;

    always_comb begin
        upd_btb_o = BTB_NOP;
        if (res_branch_i && res_taken_i && (!res_btb_hit_i || !res_predict_taken_i)) begin
            upd_btb_o = BTB_WRITE;
        end else if (res_btb_hit_i && !res_branch_i) begin
            upd_btb_o = BTB_INVAL;
        end
    end

endmodule

// File: rtl/bpu_ctrl.sv
// BPU sequencing controller: table clear sweep, update arbitration, mispredict recovery.
// Define BPU_PERF_EN to add saturating branch / mispredict performance counters.
module bpu_ctrl
    import bpu_pkg::*;
#(
    parameter int PC_W           = 12,
    parameter int IDX_W          = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_tables,
    input  logic             res_valid,
    input  logic             res_branch,
    input  logic             res_btb_hit,
    input  logic             res_predict_taken,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [PC_W-1:0]  res_target,
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_idx,
    output logic             upd_bht,
    output logic [1:0]       upd_btb,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic [PC_W-1:0]  upd_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             fetch_stall,
    output logic [1:0]       ctrl_state
`ifdef BPU_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
`endif
);

    if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 15 || CNT_W < 1) begin : g_param_check
        $error("bpu_ctrl: RECOVER_CYCLES must be 1..15 and CNT_W >= 1");
    end

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    bpu_state_e       state_q, state_d;
    logic             clr_en_q, clr_en_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [3:0]       rec_cnt_q, rec_cnt_d;
    logic             upd_bht_q, upd_bht_d;
    logic [1:0]       upd_btb_q, upd_btb_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic [PC_W-1:0]  upd_target_q, upd_target_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             fetch_stall_q, fetch_stall_d;

    logic             det_mis;
    logic [PC_W-1:0]  det_redirect_pc;
    logic             det_upd_bht;
    logic [1:0]       det_upd_btb;

    bpu_mispredict_detect #(.PC_W(PC_W)) u_detect (
        .res_valid_i         (res_valid),
        .res_branch_i        (res_branch),
        .res_btb_hit_i       (res_btb_hit),
        .res_predict_taken_i (res_predict_taken),
        .res_taken_i         (res_taken),
        .res_pc_i            (res_pc),
        .res_target_i        (res_target),
        .mis_o               (det_mis),
        .redirect_pc_o       (det_redirect_pc),
        .upd_bht_o           (det_upd_bht),
        .upd_btb_o           (det_upd_btb)
    );

    always_comb begin
        state_d          = state_q;
        clr_en_d         = 1'b0;
        clr_idx_d        = clr_idx_q;
        rec_cnt_d        = rec_cnt_q;
        upd_bht_d        = 1'b0;
        upd_btb_d        = BTB_NOP;
        upd_pc_d         = '0;
        upd_taken_d      = 1'b0;
        upd_target_d     = '0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        fetch_stall_d    = fetch_stall_q;

        case (state_q)
            INIT: begin
                fetch_stall_d = 1'b1;
                // clr_en low in INIT only happens right after reset: start the sweep at 0.
                if (!clr_en_q) begin
                    clr_en_d  = 1'b1;
                    clr_idx_d = '0;
                end else if (clr_idx_q == IDX_LAST) begin
                    state_d       = RUN;
                    clr_idx_d     = '0;
                    fetch_stall_d = 1'b0;
                end else begin
                    clr_en_d  = 1'b1;
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                fetch_stall_d = 1'b0;
                if (res_valid) begin
                    upd_bht_d    = det_upd_bht;
                    upd_btb_d    = det_upd_btb;
                    upd_pc_d     = res_pc;
                    upd_taken_d  = res_taken;
                    upd_target_d = res_target;
                end
                if (det_mis) begin
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = det_redirect_pc;
                    state_d          = RECOVER;
                    fetch_stall_d    = 1'b1;
                    rec_cnt_d        = 4'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (rec_cnt_q == '0) begin
                    state_d       = RUN;
                    fetch_stall_d = 1'b0;
                end else begin
                    rec_cnt_d     = rec_cnt_q - 4'd1;
                    fetch_stall_d = 1'b1;
                end
            end
            default: begin
                state_d       = INIT;
                fetch_stall_d = 1'b1;
            end
        endcase

        // Table flush wins over everything except an already-decided redirect pulse.
        if (flush_tables) begin
            state_d       = INIT;
            clr_en_d      = 1'b1;
            clr_idx_d     = '0;
            fetch_stall_d = 1'b1;
            upd_bht_d     = 1'b0;
            upd_btb_d     = BTB_NOP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= INIT;
            clr_en_q         <= 1'b0;
            clr_idx_q        <= '0;
            rec_cnt_q        <= '0;
            upd_bht_q        <= 1'b0;
            upd_btb_q        <= BTB_NOP;
            upd_pc_q         <= '0;
            upd_taken_q      <= 1'b0;
            upd_target_q     <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            fetch_stall_q    <= 1'b1;
        end else begin
            state_q          <= state_d;
            clr_en_q         <= clr_en_d;
            clr_idx_q        <= clr_idx_d;
            rec_cnt_q        <= rec_cnt_d;
            upd_bht_q        <= upd_bht_d;
            upd_btb_q        <= upd_btb_d;
            upd_pc_q         <= upd_pc_d;
            upd_taken_q      <= upd_taken_d;
            upd_target_q     <= upd_target_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            fetch_stall_q    <= fetch_stall_d;
        end
    end

    assign clr_en         = clr_en_q;
    assign clr_idx        = clr_idx_q;
    assign upd_bht        = upd_bht_q;
    assign upd_btb        = upd_btb_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign upd_target     = upd_target_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign fetch_stall    = fetch_stall_q;
    assign ctrl_state     = state_q;

`ifdef BPU_PERF_EN
    logic [CNT_W-1:0] perf_br_q, perf_mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else if (state_q == RUN) begin
            if (res_valid && res_branch && (perf_br_q != '1)) begin
                perf_br_q <= perf_br_q + CNT_W'(1);
            end
            if (det_mis && (perf_mis_q != '1)) begin
                perf_mis_q <= perf_mis_q + CNT_W'(1);
            end
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`endif

endmodule

// File: tb/tb_bpu_ctrl.sv
// Self-checking bench for bpu_ctrl: directed scenarios plus random resolutions vs. a reference model.
module tb_bpu_ctrl;

    localparam int PC_W  = 12;
    localparam int IDX_W = 4;
    localparam int RC    = 2;
    localparam int CNT_W = 16;
    localparam int NENT  = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush_tables = 1'b0;
    logic             res_valid = 1'b0;
    logic             res_branch = 1'b0;
    logic             res_btb_hit = 1'b0;
    logic             res_predict_taken = 1'b0;
    logic             res_taken = 1'b0;
    logic [PC_W-1:0]  res_pc = '0;
    logic [PC_W-1:0]  res_target = '0;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic             upd_bht;
    logic [1:0]       upd_btb;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic             flush;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             fetch_stall;
    logic [1:0]       ctrl_state;
`ifdef BPU_PERF_EN
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredicts;
`endif

    bpu_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .RECOVER_CYCLES(RC), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush_tables      (flush_tables),
        .res_valid         (res_valid),
        .res_branch        (res_branch),
        .res_btb_hit       (res_btb_hit),
        .res_predict_taken (res_predict_taken),
        .res_taken         (res_taken),
        .res_pc            (res_pc),
        .res_target        (res_target),
        .clr_en            (clr_en),
        .clr_idx           (clr_idx),
        .upd_bht           (upd_bht),
        .upd_btb           (upd_btb),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_target        (upd_target),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_stall       (fetch_stall),
        .ctrl_state        (ctrl_state)
`ifdef BPU_PERF_EN
        ,
        .perf_branches     (perf_branches),
        .perf_mispredicts  (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = clearing, 1 = running, 2 = recovering.
    int mode;
    int sweep_pos;     // last index driven in the sweep, -1 before the first
    int stall_left;    // stall cycles still owed after the current one
    int cnt_br, cnt_mis;
    logic            e_clr, e_bht, e_taken, e_flush, e_rv, e_stall;
    logic [IDX_W-1:0] e_idx;
    logic [1:0]      e_btb;
    logic [PC_W-1:0] e_pc, e_tgt, e_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; sweep_pos = -1; stall_left = 0;
        cnt_br = 0; cnt_mis = 0;
        e_clr = 0; e_idx = '0; e_bht = 0; e_btb = 2'b00; e_pc = '0; e_taken = 0; e_tgt = '0;
        e_flush = 0; e_rv = 0; e_rpc = '0; e_stall = 1;
    endtask

    task automatic model_edge();
        logic mis;
        int   max_cnt;
        max_cnt = (1 << CNT_W) - 1;
        mis = res_valid && ((res_branch && (res_predict_taken != res_taken)) ||
                            (!res_branch && res_btb_hit && res_predict_taken));
        e_clr = 0; e_bht = 0; e_btb = 2'b00; e_flush = 0; e_rv = 0; e_rpc = '0;
        if (mode == 1) begin
            if (res_valid && res_branch && cnt_br < max_cnt) cnt_br++;
            if (mis && cnt_mis < max_cnt) cnt_mis++;
        end
        case (mode)
            0: begin
                if (sweep_pos == NENT - 1) begin
                    mode = 1; e_stall = 0;
                end else begin
                    sweep_pos++; e_clr = 1; e_idx = IDX_W'(sweep_pos); e_stall = 1;
                end
            end
            1: begin
                e_stall = 0;
                if (res_valid) begin
                    e_bht = res_branch;
                    if (res_branch && res_taken && !(res_btb_hit && res_predict_taken)) e_btb = 2'b01;
                    else if (res_btb_hit && !res_branch) e_btb = 2'b10;
                    e_pc = res_pc; e_taken = res_taken; e_tgt = res_target;
                end
                if (mis) begin
                    e_flush = 1; e_rv = 1;
                    e_rpc = (res_branch && res_taken) ? res_target
                                                      : PC_W'((int'(res_pc) + 4) % (1 << PC_W));
                    mode = 2; e_stall = 1; stall_left = RC - 1;
                end
            end
            default: begin
                if (stall_left == 0) begin
                    mode = 1; e_stall = 0;
                end else begin
                    stall_left--; e_stall = 1;
                end
            end
        endcase
        if (flush_tables) begin
            mode = 0; sweep_pos = 0; e_clr = 1; e_idx = '0; e_stall = 1;
            e_bht = 0; e_btb = 2'b00;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".state"}, 32'(ctrl_state), 32'(mode));
        chk({ctx, ".clr_en"}, 32'(clr_en), 32'(e_clr));
        if (e_clr) chk({ctx, ".clr_idx"}, 32'(clr_idx), 32'(e_idx));
        chk({ctx, ".stall"}, 32'(fetch_stall), 32'(e_stall));
        chk({ctx, ".upd_bht"}, 32'(upd_bht), 32'(e_bht));
        chk({ctx, ".upd_btb"}, 32'(upd_btb), 32'(e_btb));
        if (e_bht || e_btb != 2'b00) begin
            chk({ctx, ".upd_pc"}, 32'(upd_pc), 32'(e_pc));
            chk({ctx, ".upd_taken"}, 32'(upd_taken), 32'(e_taken));
            chk({ctx, ".upd_target"}, 32'(upd_target), 32'(e_tgt));
        end
        chk({ctx, ".flush"}, 32'(flush), 32'(e_flush));
        chk({ctx, ".redirect_valid"}, 32'(redirect_valid), 32'(e_rv));
        if (e_rv) chk({ctx, ".redirect_pc"}, 32'(redirect_pc), 32'(e_rpc));
`ifdef BPU_PERF_EN
        chk({ctx, ".perf_br"}, 32'(perf_branches), 32'(cnt_br));
        chk({ctx, ".perf_mis"}, 32'(perf_mispredicts), 32'(cnt_mis));
`endif
    endtask

    task automatic cyc(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input logic v, input logic br, input logic hit, input logic pred,
                         input logic tk, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                         input logic ft);
        res_valid = v; res_branch = br; res_btb_hit = hit; res_predict_taken = pred;
        res_taken = tk; res_pc = pc; res_target = tgt; flush_tables = ft;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic check_reset_values(input string ctx);
        chk({ctx, ".state"}, 32'(ctrl_state), 32'd0);
        chk({ctx, ".clr_en"}, 32'(clr_en), 32'd0);
        chk({ctx, ".clr_idx"}, 32'(clr_idx), 32'd0);
        chk({ctx, ".stall"}, 32'(fetch_stall), 32'd1);
        chk({ctx, ".upd"}, 32'({upd_bht, upd_btb, upd_taken}), 32'd0);
        chk({ctx, ".upd_pc"}, 32'(upd_pc), 32'd0);
        chk({ctx, ".upd_target"}, 32'(upd_target), 32'd0);
        chk({ctx, ".redirect"}, 32'({flush, redirect_valid}), 32'd0);
        chk({ctx, ".redirect_pc"}, 32'(redirect_pc), 32'd0);
    endtask

    task automatic wait_run(input string ctx);
        int n;
        n = 0;
        idle();
        while (mode != 1 && n < 4 * NENT) begin
            cyc(ctx);
            n++;
        end
        chk({ctx, ".reached_run"}, 32'(mode), 32'd1);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        // Post-reset sweep: 16 clear cycles then RUN
        for (int i = 0; i < NENT; i++) begin
            cyc("sweep");
            chk("sweep.idx_seq", 32'(clr_idx), 32'(i));
        end
        cyc("sweep_end");
        chk("sweep_end.run", 32'(ctrl_state), 32'd1);

        // Taken branch predicted not-taken, BTB miss
        drive(1, 1, 0, 0, 1, 12'h100, 12'h040, 0);
        cyc("mis_br");
        chk("mis_br.rpc_const", 32'(redirect_pc), 32'h040);
        chk("mis_br.btb_const", 32'(upd_btb), 32'd1);
        idle();
        cyc("mis_br.rec1");
        cyc("mis_br.rec2");
        chk("mis_br.resume", 32'(fetch_stall), 32'd0);

        // Non-branch BTB hit predicted taken at the top of the address space
        drive(1, 0, 1, 1, 0, 12'hFFC, 12'h123, 0);
        cyc("mis_wrap");
        chk("mis_wrap.rpc_const", 32'(redirect_pc), 32'h000);
        chk("mis_wrap.btb_const", 32'(upd_btb), 32'd2);
        // Wrong-path resolution during recovery must be ignored
        drive(1, 1, 0, 0, 1, 12'h200, 12'h300, 0);
        cyc("wrongpath1");
        cyc("wrongpath2");

        // Correctly predicted taken branch
        drive(1, 1, 1, 1, 1, 12'h080, 12'h0C0, 0);
        cyc("correct");
        chk("correct.flush_const", 32'(flush), 32'd0);
        chk("correct.bht_const", 32'(upd_bht), 32'd1);

        // flush_tables together with a mispredict
        drive(1, 1, 1, 1, 0, 12'h3A0, 12'h500, 1);
        cyc("ft_mis");
        chk("ft_mis.rv_const", 32'(redirect_valid), 32'd1);
        chk("ft_mis.rpc_const", 32'(redirect_pc), 32'h3A4);
        idle();
        while (sweep_pos < 7) cyc("ft_sweep");
        drive(0, 0, 0, 0, 0, '0, '0, 1);
        cyc("ft_restart");
        chk("ft_restart.idx_const", 32'(clr_idx), 32'd0);

        // Async reset mid-sweep at index 5
        idle();
        while (sweep_pos < 5) cyc("pre_rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_mid_sweep");
        @(posedge clk); #1;
        reset = 1'b1;
        cyc("rst_sweep0");
        chk("rst_sweep0.idx_const", 32'(clr_idx), 32'd0);
        wait_run("rst_to_run");

        // Async reset mid-recovery
        drive(1, 1, 0, 1, 0, 12'h010, 12'h020, 0);
        cyc("mis_before_rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("rst_mid_recover");
        @(posedge clk); #1;
        reset = 1'b1;
        wait_run("rst2_to_run");

        // Random resolutions
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  PC_W'($urandom), PC_W'($urandom), $urandom_range(0, 99) < 2);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bpu_ctrl.md
Name: bpu_ctrl

Overview:
- Sequencing controller around the branch prediction unit.
- Runs a post-reset / on-demand clear sweep of the BTB and BHT entries, and arbitrates table updates from EX/MEM branch resolutions.
- Detects mispredictions and drives the pipeline flush, fetch redirect and the recovery stall window.
- Sits between the EX/MEM register, the prediction tables and the fetch stage.

Parameters:
- PC_W, 12, program-counter width.
- IDX_W, 4, table index width; the tables hold 2**IDX_W entries.
- RECOVER_CYCLES, 2, fetch-stall cycles after a redirect; legal range 1..15.
- CNT_W, 16, performance counter width. Used only with BPU_PERF_EN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_tables  in  1  request to re-clear both tables.
- res_valid  in  1  EX/MEM slot holds a valid instruction.
- res_branch  in  1  the instruction is a branch or jump.
- res_btb_hit  in  1  the instruction hit in the BTB at fetch.
- res_predict_taken  in  1  taken prediction made at fetch.
- res_taken  in  1  resolved direction.
- res_pc  in  PC_W  instruction PC.
- res_target  in  PC_W  resolved target.
- clr_en  out  1  clear the entry at clr_idx in both BTB and BHT.
- clr_idx  out  IDX_W  index being cleared.
- upd_bht  out  1  BHT update strobe.
- upd_btb  out  2  BTB operation: 00 none, 01 write target, 10 invalidate.
- upd_pc  out  PC_W  PC for the update.
- upd_taken  out  1  direction for the update.
- upd_target  out  PC_W  target for the update.
- flush  out  1  flush the IF/ID and ID/EX registers.
- redirect_valid  out  1  load redirect_pc into the PC.
- redirect_pc  out  PC_W  corrected fetch PC.
- fetch_stall  out  1  hold fetch.
- ctrl_state  out  2  state: 00 INIT, 01 RUN, 10 RECOVER.

Behaviour:
- All outputs are registered, with 1-cycle latency from the sampled inputs.
- While reset is low:
  - State is INIT, clr_idx=0, fetch_stall=1.
  - All other outputs are 0.
- INIT:
  - Each cycle drives clr_en=1 and clr_idx=k, with k counting 0..2**IDX_W-1.
  - After idx 2**IDX_W-1 is driven, the next cycle is RUN with clr_en=0 and fetch_stall=0.
  - The sweep therefore lasts exactly 2**IDX_W clr_en cycles.
  - Resolutions are ignored in INIT.
- Mispredict term (evaluated in RUN only), mis = res_valid && ((res_branch && res_predict_taken!=res_taken) || (!res_branch && res_btb_hit && res_predict_taken)).
- Update generation in RUN when res_valid (registered, next cycle):
  - upd_bht=res_branch.
  - upd_btb=01 if res_branch && res_taken && (!res_btb_hit || !res_predict_taken).
  - upd_btb=10 if res_btb_hit && !res_branch.
  - upd_btb=00 otherwise.
  - upd_pc, upd_taken and upd_target copy the inputs.
  - All upd_* strobes are 0 when not in RUN.
- Redirect and recovery:
  - Trigger: mis in RUN at cycle N.
  - Cycle N+1: flush=1 and redirect_valid=1 for exactly one cycle.
  - redirect_pc = (res_branch && res_taken) ? res_target : res_pc+4, truncated to PC_W (wraps).
  - State goes to RECOVER; fetch_stall=1 for cycles N+1..N+RECOVER_CYCLES.
  - RUN resumes at N+RECOVER_CYCLES+1.
  - Resolutions arriving during RECOVER are wrong-path: no updates, no redirect.
- flush_tables:
  - Sampled in any state; highest priority.
  - Next cycle: INIT, clr_idx restarts at 0, fetch_stall=1.
  - If it coincides with a RUN mispredict, the flush/redirect pulse is still issued and upd_* strobes are suppressed.
  - In INIT it restarts the sweep from 0.
- Reset asserted mid-sweep or mid-recovery: immediately returns to the reset values above.

Optional Feature:
- BPU_PERF_EN defined:
  - Adds outputs perf_branches and perf_mispredicts, each CNT_W wide, reset to 0.
  - perf_branches increments on res_valid && res_branch in RUN; perf_mispredicts increments on mis.
  - Both saturate at all-ones.
  - flush_tables does not clear them.
- BPU_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bpu_pkg holds:
  - state encodings INIT=2'b00, RUN=2'b01, RECOVER=2'b10;
  - BTB op codes BTB_NOP, BTB_WRITE, BTB_INVAL;
  - PC_INC=4.
- One sub-module, bpu_mispredict_detect (combinational): computes mis, the redirect PC and the update ops. The FSM, sweep counter and recovery counter stay in bpu_ctrl.

Test Plan:
- Release reset, IDX_W=4 -> clr_en high for 16 cycles with clr_idx 0..15, fetch_stall=1 throughout; then ctrl_state=01 and fetch_stall=0.
- RUN, res_branch=1, pred=0, taken=1, btb_hit=0, pc=0x100, target=0x040 -> next cycle:
  - flush=redirect_valid=1, redirect_pc=0x040, upd_btb=01, upd_bht=1;
  - fetch_stall high for 2 cycles, then RUN.
- Non-branch, btb_hit=1, pred=1, pc=0xFFC -> redirect_pc=0x000 (wrap), upd_btb=10, upd_bht=0.
- Correct prediction, taken=1, pred=1, btb_hit=1 -> flush=0, upd_btb=00, upd_bht=1.
- flush_tables in the same cycle as a mispredict -> redirect pulse issued, upd_* all 0, sweep restarts at idx 0; a second flush_tables at idx 7 -> clr_idx returns to 0.
- Reset asserted at clr_idx=5 -> outputs immediately return to reset values; after release the sweep restarts from 0. With BPU_PERF_EN and CNT_W=2, 5 mispredicts -> perf_mispredicts=3 (saturated).
